// File: rtl/des_key_sched_dec.sv
// DES decryption key schedule: emits the 16 C/D round-key halves in K16..K1 order, one per handshake.
// Optional PC-2 output k_out is built when DES_KS_PC2_EN is defined.
module des_key_sched_dec #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [27:0] c_in,
    input  logic [27:0] d_in,
    output logic        busy,
    output logic        round_valid,
    input  logic        round_ready,
    output logic [3:0]  round_idx,
    output logic [27:0] c_out,
    output logic [27:0] d_out,
    output logic        done
`ifdef DES_KS_PC2_EN
   ,output logic [47:0] k_out
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state, state_nxt;
    logic       accept;
    logic       last_round;
    logic [3:0] idx_nxt;
    logic       rot_one;

    // Right rotate by one or two positions; a per-bit 2:1 mux, no arithmetic.
    function automatic logic [27:0] rotr_sel(input logic [27:0] x, input logic one);
        logic [27:0] r1;
        logic [27:0] r2;
        r1 = {x[0], x[27:1]};
        r2 = {x[1:0], x[27:2]};
        return one ? r1 : r2;
    endfunction

    assign accept     = round_valid & round_ready;
    assign last_round = (round_idx == 4'(ROUNDS - 1));
    assign idx_nxt    = round_idx + 4'd1;
    assign rot_one    = (idx_nxt == 4'd1) || (idx_nxt == 4'd8) || (idx_nxt == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            round_idx <= 4'd0;
            c_out     <= 28'd0;
            d_out     <= 28'd0;
        end else begin
            state <= state_nxt;
            done  <= (state == RUN) && accept && last_round;
            if (state == IDLE && start) begin
                round_idx <= 4'd0;
                c_out     <= c_in;
                d_out     <= d_in;
            end else if (state == RUN && accept && !last_round) begin
                round_idx <= idx_nxt;
                c_out     <= rotr_sel(c_out, rot_one);
                d_out     <= rotr_sel(d_out, rot_one);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && last_round) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == RUN);
        round_valid = (state == RUN);
    end

`ifdef DES_KS_PC2_EN
    // PC-2 positions are 1-based from the MSB of the 56-bit {C,D} word.
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] k;
        k = '0;
        for (int i = 0; i < 48; i++) begin
            k[47 - i] = cd[56 - PC2[i]];
        end
        return k;
    endfunction

    assign k_out = pc2({c_out, d_out});
`endif

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Scoreboard bench for des_key_sched_dec: expected rounds are queued when a run is launched
// and compared on every accepted handshake; directed scenarios cover stall, ignored start, reset and restart.
module tb_des_key_sched_dec;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [27:0] c_in;
    logic [27:0] d_in;
    logic        busy;
    logic        round_valid;
    logic        round_ready;
    logic [3:0]  round_idx;
    logic [27:0] c_out;
    logic [27:0] d_out;
    logic        done;
`ifdef DES_KS_PC2_EN
    logic [47:0] k_out;
`endif

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    logic [59:0] sb [$];

    // Per-round right-rotation amount of the decryption schedule.
    localparam int SH [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_sched_dec dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .c_in        (c_in),
        .d_in        (d_in),
        .busy        (busy),
        .round_valid (round_valid),
        .round_ready (round_ready),
        .round_idx   (round_idx),
        .c_out       (c_out),
        .d_out       (d_out),
        .done        (done)
`ifdef DES_KS_PC2_EN
       ,.k_out       (k_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] rotr(input logic [27:0] x, input int n);
        logic [27:0] r;
        r = x;
        for (int s = 0; s < n; s++) begin
            r = {r[0], r[27:1]};
        end
        return r;
    endfunction

    task automatic push_run(input logic [27:0] c0, input logic [27:0] d0);
        logic [27:0] c;
        logic [27:0] d;
        c = c0;
        d = d0;
        for (int k = 0; k < 16; k++) begin
            c = rotr(c, SH[k]);
            d = rotr(d, SH[k]);
            sb.push_back({4'(k), c, d});
        end
    endtask

    // Monitor: sample at the falling edge, between active edges.
    always @(negedge clk) begin
        logic [59:0] e;
        if (rst) begin
            sb.delete();
        end else begin
            if (done) begin
                done_count++;
                check("done_sb_empty", 64'(sb.size()), 64'd0);
            end
            if (round_valid && round_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_round", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("round", {4'd0, round_idx, c_out, d_out}, {4'd0, e});
                end
            end
            if (start && !busy) push_run(c_in, d_in);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < budget);
        if (!done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idx(input logic [3:0] target);
        int n;
        n = 0;
        while (!(round_valid && round_idx == target) && n < 60) begin
            tick();
            n++;
        end
        if (!(round_valid && round_idx == target)) check("idx_timeout", 64'(round_idx), 64'(target));
    endtask

    task automatic pulse_start(input logic [27:0] c0, input logic [27:0] d0);
        c_in  = c0;
        d_in  = d0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        int dc;
        logic [60:0] snap;

        rst = 1'b1;
        start = 1'b0;
        round_ready = 1'b1;
        c_in = '0;
        d_in = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_valid", 64'(round_valid), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_idx",   64'(round_idx), 64'd0);
        check("rst_c",     64'(c_out), 64'd0);
        check("rst_d",     64'(d_out), 64'd0);

        // Scenario 1: rotation amounts, no stall, start-to-done latency.
        pulse_start(28'h0000001, 28'h8000000);
        n = 1;
        check("s1_idx0_c", 64'(c_out), 64'h0000001);
        check("s1_idx0_d", 64'(d_out), 64'h8000000);
        while (!done && n < 40) begin
            tick();
            n++;
            if (round_valid && round_idx == 4'd1) check("s1_idx1", {8'd0, c_out, d_out}, {8'd0, 28'h8000000, 28'h4000000});
            if (round_valid && round_idx == 4'd2) check("s1_idx2", {8'd0, c_out, d_out}, {8'd0, 28'h2000000, 28'h1000000});
            if (round_valid && round_idx == 4'd15) check("s1_idx15", {8'd0, c_out, d_out}, {8'd0, 28'h0000002, 28'h0000001});
        end
        check("s1_latency", 64'(n), 64'd17);
        check("s1_busy_at_done", 64'(busy), 64'd0);
        tick();
        check("s1_done_pulse", 64'(done), 64'd0);
        check("s1_hold_c", 64'(c_out), 64'h0000002);

        // Scenario 2: FIPS key vector.
        pulse_start(28'hF0CCAAF, 28'h556678F);
`ifdef DES_KS_PC2_EN
        check("s2_k16", 64'(k_out), 64'hCB3D8B0E17F5);
`endif
        wait_idx(4'd15);
`ifdef DES_KS_PC2_EN
        check("s2_k1", 64'(k_out), 64'h1B02EFFC7072);
`endif
        check("s2_c1d1", {8'd0, c_out, d_out}, {8'd0, 28'hE19955F, 28'hAACCF1E});
        wait_done(20, n);

        // Scenario 3: five-cycle stall at idx3.
        tick();
        pulse_start(28'h0000001, 28'h8000000);
        wait_idx(4'd3);
        round_ready = 1'b0;
        snap = {round_valid, round_idx, c_out, d_out};
        repeat (5) begin
            tick();
            check("s3_stall_hold", {3'd0, round_valid, round_idx, c_out, d_out}, {3'd0, snap});
        end
        round_ready = 1'b1;
        tick();
        check("s3_resume", {4'd0, round_idx, c_out, d_out}, {4'd0, 4'd4, 28'h0200000, 28'h0100000});
        wait_done(20, n);

        // Scenario 4: start while busy is ignored.
        tick();
        pulse_start(28'h0000001, 28'h8000000);
        wait_idx(4'd7);
        pulse_start(28'h5A5A5A5, 28'hA5A5A5A);
        check("s4_idx_after_start", 64'(round_idx), 64'd8);
        wait_done(20, n);
        check("s4_final", {8'd0, c_out, d_out}, {8'd0, 28'h0000002, 28'h0000001});

        // Scenario 5: reset mid-run aborts without done.
        tick();
        pulse_start(28'h1234567, 28'h89ABCDE);
        wait_idx(4'd9);
        dc = done_count;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s5_rst_outs", {3'd0, busy, round_valid, done, round_idx, c_out, d_out},
              {3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 28'd0, 28'd0});
        repeat (3) tick();
        check("s5_no_done", 64'(done_count), 64'(dc));
        pulse_start(28'hF0CCAAF, 28'h556678F);
        wait_done(20, n);
        check("s5_final", {8'd0, c_out, d_out}, {8'd0, 28'hE19955F, 28'hAACCF1E});

        // Scenario 6: start held high, random back-pressure.
        tick();
        c_in = 28'hABCDEF1;
        d_in = 28'h1357924;
        start = 1'b1;
        for (int i = 0; i < 80 && !done; i++) begin
            round_ready = 1'($urandom_range(0, 1));
            tick();
        end
        round_ready = 1'b1;
        if (!done) wait_done(20, n);
        check("s6_done", 64'(done), 64'd1);
        c_in = 28'h0F0F0F0;
        d_in = 28'h7777777;
        tick();
        check("s6_restart", {3'd0, busy, round_valid, round_idx, c_out, d_out},
              {3'd0, 1'b1, 1'b1, 4'd0, 28'h0F0F0F0, 28'h7777777});
        start = 1'b0;
        wait_done(20, n);

        tick();
        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
